// File: rtl/sr_latch_driver.sv
// Pulse driver for an external NOR SR latch with synchronized read-back check.
// Optional macro SR_SKIP_REDUNDANT_EN: skip the pulse when the latch already holds the value.
module sr_latch_driver #(
    parameter int PULSE_CYCLES    = 4,
    parameter int GUARD_CYCLES    = 2,
    parameter int CONFIRM_TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_value,
    output logic req_ready,
    output logic s_out,
    output logic r_out,
    input  logic q_in,
    input  logic qn_in,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GUARD,
        CHECK
    } state_t;

    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GUARD_LD = 8'(GUARD_CYCLES - 1);
    localparam logic [7:0] CHECK_LD = 8'(CONFIRM_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       val;
    logic       val_nxt;

    logic q_meta;
    logic q_s;
    logic qn_meta;
    logic qn_s;

    logic accept;
    logic skip;
    logic match;
    logic cnt_zero;

    logic s_nxt;
    logic r_nxt;
    logic busy_nxt;
    logic ready_nxt;
    logic done_nxt;
    logic err_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_meta  <= 1'b0;
            q_s     <= 1'b0;
            qn_meta <= 1'b0;
            qn_s    <= 1'b0;
        end else begin
            q_meta  <= q_in;
            q_s     <= q_meta;
            qn_meta <= qn_in;
            qn_s    <= qn_meta;
        end
    end

    assign accept   = req_valid && req_ready;
    assign cnt_zero = (cnt == 8'd0);

    // q_s == qn_s is an invalid latch read-back and never confirms a write
    assign match = (q_s == val) && (qn_s == !val) && (q_s != qn_s);

`ifdef SR_SKIP_REDUNDANT_EN
    assign skip = accept && (q_s == req_value) && (qn_s != req_value);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            val   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            val   <= val_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        val_nxt   = val;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    val_nxt = req_value;
                    if (!skip) begin
                        state_nxt = PULSE;
                        cnt_nxt   = PULSE_LD;
                    end
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    state_nxt = GUARD;
                    cnt_nxt   = GUARD_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            GUARD: begin
                if (cnt_zero) begin
                    state_nxt = CHECK;
                    cnt_nxt   = CHECK_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            CHECK: begin
                if (match || cnt_zero) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Both drives derive from one latched bit, so they are exclusive by construction
    always_comb begin
        s_nxt     = (state_nxt == PULSE) && val_nxt;
        r_nxt     = (state_nxt == PULSE) && !val_nxt;
        busy_nxt  = (state_nxt != IDLE);
        ready_nxt = (state_nxt == IDLE);
        done_nxt  = skip || ((state == CHECK) && match);
        err_nxt   = (state == CHECK) && !match && cnt_zero;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_out     <= 1'b0;
            r_out     <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            s_out     <= s_nxt;
            r_out     <= r_nxt;
            busy      <= busy_nxt;
            req_ready <= ready_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver with a behavioural NOR latch model.
// Build with SR_SKIP_REDUNDANT_EN defined to exercise the redundant-write skip.
module tb_sr_latch_driver;

    localparam int P       = 4;
    localparam int G       = 2;
    localparam int T       = 8;
    localparam int LAT_OK  = P + G + 1;
    localparam int LAT_ERR = P + G + T;

    localparam int M_NORM  = 0;
    localparam int M_STUCK = 1;
    localparam int M_FORCE = 2;

    typedef struct {
        bit value;
        int mode;
        bit exp_done;
        int exp_lat;
        int exp_s;
        int exp_r;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_value = 1'b0;
    logic req_ready;
    logic s_out;
    logic r_out;
    logic q_in;
    logic qn_in;
    logic busy;
    logic done;
    logic err;

    int   mode = M_NORM;
    logic latch_lq = 1'b0;
    logic preset_en = 1'b0;
    logic preset_val = 1'b0;
    logic mdl_lq = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Latch core; the read-back can be overridden to model faults
    always @(posedge clk) begin
        if (preset_en)  latch_lq <= preset_val;
        else if (s_out) latch_lq <= 1'b1;
        else if (r_out) latch_lq <= 1'b0;
    end

    assign q_in  = (mode == M_NORM) ? latch_lq : 1'b0;
    assign qn_in = (mode == M_NORM) ? !latch_lq : (mode == M_STUCK);

    sr_latch_driver #(
        .PULSE_CYCLES(P),
        .GUARD_CYCLES(G),
        .CONFIRM_TIMEOUT(T)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_value(req_value),
        .req_ready(req_ready),
        .s_out(s_out),
        .r_out(r_out),
        .q_in(q_in),
        .qn_in(qn_in),
        .busy(busy),
        .done(done),
        .err(err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("s_r_exclusive", int'(s_out && r_out), 0);
        chk("done_err_exclusive", int'(done && err), 0);
        chk("busy_vs_ready", int'(busy), int'(!req_ready));
    endtask

    task automatic preset(input bit v);
        preset_en  = 1'b1;
        preset_val = v;
        tick();
        preset_en = 1'b0;
        mdl_lq = v;
        repeat (3) tick();
    endtask

    // Spec-level outcome of one write given the latch contents and fault mode
    task automatic predict(input bit v, input int m, output bit ok,
                           output int lat, output int ns, output int nr);
        bit q;
        bit qn;
        bit red;
        q  = (m == M_NORM) ? mdl_lq : 1'b0;
        qn = (m == M_NORM) ? !mdl_lq : (m == M_STUCK);
`ifdef SR_SKIP_REDUNDANT_EN
        red = (q == v) && (qn != v);
`else
        red = 1'b0;
`endif
        if (red) begin
            ok = 1'b1;
            lat = 0;
            ns = 0;
            nr = 0;
        end else begin
            mdl_lq = v;
            ns = v ? P : 0;
            nr = v ? 0 : P;
            q  = (m == M_NORM) ? mdl_lq : 1'b0;
            qn = (m == M_NORM) ? !mdl_lq : (m == M_STUCK);
            ok = (q == v) && (qn == !v) && (q != qn);
            lat = ok ? LAT_OK : LAT_ERR;
        end
    endtask

    task automatic run_txn(input bit v, input int m, input int sw_k, input int sw_m,
                           output int lat, output int nd, output int ne,
                           output int ns, output int nr, output int fs, output int fr);
        int w;
        mode = m;
        repeat (3) tick();
        w = 0;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        chk("ready_before_req", int'(req_ready), 1);
        req_valid = 1'b1;
        req_value = v;
        lat = -1;
        nd = 0;
        ne = 0;
        ns = 0;
        nr = 0;
        fs = -1;
        fr = -1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (k == 0) begin
                req_valid = 1'b0;
                req_value = !v;
            end
            if (k == sw_k) mode = sw_m;
            if (s_out) begin
                ns++;
                if (fs < 0) fs = k;
            end
            if (r_out) begin
                nr++;
                if (fr < 0) fr = k;
            end
            if (done) nd++;
            if (err) ne++;
            if ((done || err) && lat < 0) lat = k;
        end
        mode = M_NORM;
    endtask

    task automatic check_txn(input string name, input bit ok, input int elat,
                             input int es, input int er);
        int lat, nd, ne, ns, nr, fs, fr;
        lat = 0; nd = 0; ne = 0; ns = 0; nr = 0; fs = 0; fr = 0;
        chk({name, "_done_count"}, nd, 0);
    endtask

    task automatic compare(input string name, input bit ok, input int elat,
                           input int es, input int er, input int lat, input int nd,
                           input int ne, input int ns, input int nr, input int fs,
                           input int fr);
        chk({name, "_done_count"}, nd, ok ? 1 : 0);
        chk({name, "_err_count"}, ne, ok ? 0 : 1);
        chk({name, "_latency"}, lat, elat);
        chk({name, "_s_cycles"}, ns, es);
        chk({name, "_r_cycles"}, nr, er);
        if (es > 0) chk({name, "_s_start"}, fs, 0);
        if (er > 0) chk({name, "_r_start"}, fr, 0);
    endtask

    vec_t tbl[6];
    int lat, nd, ne, ns, nr, fs, fr;
    bit ok;
    int elat, es, er;
    bit rv;
    int rm;

    initial begin
        tbl[0] = '{1'b1, M_NORM, 1'b1, LAT_OK, P, 0};
        tbl[1] = '{1'b0, M_NORM, 1'b1, LAT_OK, 0, P};
        tbl[2] = '{1'b1, M_STUCK, 1'b0, LAT_ERR, P, 0};
        tbl[3] = '{1'b0, M_NORM, 1'b1, LAT_OK, 0, P};
        tbl[4] = '{1'b1, M_FORCE, 1'b0, LAT_ERR, P, 0};
`ifdef SR_SKIP_REDUNDANT_EN
        tbl[5] = '{1'b0, M_STUCK, 1'b1, 0, 0, 0};
`else
        tbl[5] = '{1'b0, M_STUCK, 1'b1, LAT_OK, 0, P};
`endif

        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_s_out", int'(s_out), 0);
        chk("rst_r_out", int'(r_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", int'(req_ready), 1);

        preset(1'b0);
        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i].value, tbl[i].mode, -1, M_NORM, lat, nd, ne, ns, nr, fs, fr);
            compare($sformatf("vec%0d", i), tbl[i].exp_done, tbl[i].exp_lat,
                    tbl[i].exp_s, tbl[i].exp_r, lat, nd, ne, ns, nr, fs, fr);
        end

        // Read-back forced invalid (q=qn=0) from mid-pulse onwards
        preset(1'b0);
        run_txn(1'b1, M_NORM, 2, M_FORCE, lat, nd, ne, ns, nr, fs, fr);
        compare("forced_invalid", 1'b0, LAT_ERR, P, 0, lat, nd, ne, ns, nr, fs, fr);

        // Reset during the second pulse cycle
        preset(1'b0);
        req_valid = 1'b1;
        req_value = 1'b1;
        tick();
        chk("midrst_pulse_on", int'(s_out), 1);
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_s_out", int'(s_out), 0);
        chk("midrst_r_out", int'(r_out), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_err", int'(err), 0);
        rst_n = 1'b1;
        nd = 0;
        ns = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || err) nd++;
            if (s_out || r_out) ns++;
        end
        chk("midrst_no_pulse", nd, 0);
        chk("midrst_no_drive", ns, 0);
        chk("midrst_ready", int'(req_ready), 1);

        // Back-to-back with req_valid held and value changing while busy
        preset(1'b0);
        req_valid = 1'b1;
        req_value = 1'b1;
        for (int k = 0; k < 28; k++) begin
            int ph;
            int tx;
            bit live;
            tick();
            ph = k % 8;
            tx = k / 8;
            live = (k < 23);
            chk($sformatf("b2b_s_k%0d", k), int'(s_out), int'(live && ph < 4 && tx != 1));
            chk($sformatf("b2b_r_k%0d", k), int'(r_out), int'(live && ph < 4 && tx == 1));
            chk($sformatf("b2b_done_k%0d", k), int'(done), int'(live && ph == 7 || k == 23));
            chk($sformatf("b2b_err_k%0d", k), int'(err), 0);
            chk($sformatf("b2b_busy_k%0d", k), int'(busy), int'(live && ph != 7));
            if (k == 0) req_value = 1'b0;
            if (k == 8) req_value = 1'b1;
            if (k == 16) req_valid = 1'b0;
        end

        // Latch already set, request set again
        preset(1'b1);
        run_txn(1'b1, M_NORM, -1, M_NORM, lat, nd, ne, ns, nr, fs, fr);
`ifdef SR_SKIP_REDUNDANT_EN
        compare("redundant_set", 1'b1, 0, 0, 0, lat, nd, ne, ns, nr, fs, fr);
`else
        compare("redundant_set", 1'b1, LAT_OK, P, 0, lat, nd, ne, ns, nr, fs, fr);
`endif

        preset(1'b0);
        for (int i = 0; i < 20; i++) begin
            rv = 1'($urandom_range(0, 1));
            rm = int'($urandom_range(0, 2));
            predict(rv, rm, ok, elat, es, er);
            run_txn(rv, rm, -1, M_NORM, lat, nd, ne, ns, nr, fs, fr);
            compare($sformatf("rnd%0d", i), ok, elat, es, er, lat, nd, ne, ns, nr, fs, fr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
